// File: rtl/circuit_2_sweeper.sv
// Sweeps all 16 {A,B,C,D} vectors into Circuit_2 and checks {Out_1,Out_2,Out_3} against EXPECTED.
// Latency: SETTLE_CYCLES+2 cycles per vector; Done one cycle after the DONE state. Abort ends a sweep at the next edge.
module circuit_2_sweeper #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [47:0] EXPECTED      = 48'h6B82_6069_02F0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Abort,
    input  logic        Out_1,
    input  logic        Out_2,
    input  logic        Out_3,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        Busy,
    output logic        Done,
    output logic        Aborted,
    output logic        Pass,
    output logic [4:0]  Fail_Count,
    output logic [15:0] Fail_Mask,
    output logic [3:0]  First_Fail
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

    logic [1:0] state;
    logic [3:0] index;
    logic [7:0] settle_cnt;
    logic [5:0] exp_base;
    logic [2:0] exp_bits;
    logic       mismatch;

    assign exp_base = 6'(index) * 6'd3;
    assign exp_bits = EXPECTED[exp_base +: 3];
    assign mismatch = ({Out_1, Out_2, Out_3} != exp_bits);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= S_IDLE;
            index        <= 4'd0;
            settle_cnt   <= 8'd0;
            {A, B, C, D} <= 4'd0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Aborted      <= 1'b0;
            Pass         <= 1'b0;
            Fail_Count   <= 5'd0;
            Fail_Mask    <= 16'd0;
            First_Fail   <= 4'd0;
        end else begin
            Done    <= 1'b0;
            Aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Abort is meaningless here, so Start always wins.
                    if (Start) begin
                        index        <= 4'd0;
                        {A, B, C, D} <= 4'd0;
                        settle_cnt   <= SETTLE_INIT;
                        Pass         <= 1'b0;
                        Fail_Count   <= 5'd0;
                        Fail_Mask    <= 16'd0;
                        First_Fail   <= 4'd0;
                        Busy         <= 1'b1;
                        state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (Abort) begin
                        state        <= S_IDLE;
                        Busy         <= 1'b0;
                        Aborted      <= 1'b1;
                        {A, B, C, D} <= 4'd0;
                        Pass         <= 1'b0;
                    end else if (settle_cnt == 8'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (Abort) begin
                        // Partial results stay visible; this vector is not judged.
                        state        <= S_IDLE;
                        Busy         <= 1'b0;
                        Aborted      <= 1'b1;
                        {A, B, C, D} <= 4'd0;
                        Pass         <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            Fail_Mask[index] <= 1'b1;
                            Fail_Count       <= Fail_Count + 5'd1;
                            if (Fail_Count == 5'd0) begin
                                First_Fail <= index;
                            end
                        end
                        if (index == 4'd15) begin
                            Busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            index        <= index + 4'd1;
                            {A, B, C, D} <= index + 4'd1;
                            settle_cnt   <= SETTLE_INIT;
                            state        <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    Done  <= 1'b1;
                    Pass  <= (Fail_Count == 5'd0);
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circuit_2_sweeper.sv
// Bench for circuit_2_sweeper: a Circuit_2 model feeds two sweepers (SETTLE_CYCLES 2 and 0);
// stimulus queues expected output snapshots per cycle, a negedge monitor pops and compares them.
module tb_circuit_2_sweeper;

    // Circuit_2 truth table {Out_1,Out_2,Out_3} for vectors 0..15, decoded by hand.
    localparam logic [2:0] TT [16] = '{3'd0, 3'd6, 3'd3, 3'd1, 3'd0, 3'd2, 3'd2, 3'd3,
                                       3'd0, 3'd4, 3'd1, 3'd1, 3'd0, 3'd7, 3'd2, 3'd3};

    typedef struct {
        int          inst;
        int          cyc;
        bit          full;
        string       name;
        logic [32:0] exp;
    } snap_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        rst   [2];
    logic        start [2];
    logic        abort [2];
    logic        o1 [2], o2 [2], o3 [2];
    logic        a [2], b [2], c [2], d [2];
    logic        busy [2], done [2], aborted [2], pass [2];
    logic [4:0]  fc [2];
    logic [15:0] fm [2];
    logic [3:0]  ff [2];
    logic [3:0]  vec [2];
    bit          stuck3 = 1'b0;
    logic [15:0] flip_mask = 16'd0;
    snap_t       sq [$];
    snap_t       cur;
    bit          cov [2];
    logic [32:0] act;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] model(input logic [3:0] v, input bit st, input logic [15:0] fl);
        logic [2:0] t;
        t = TT[v];
        if (fl[v]) t[1] = ~t[1];
        if (st) t[0] = 1'b0;
        return t;
    endfunction

    function automatic logic [32:0] pack(input logic [3:0] v, input logic bz, input logic dn,
                                         input logic ab, input logic ps, input logic [4:0] f_c,
                                         input logic [15:0] f_m, input logic [3:0] f_f);
        return {v, bz, dn, ab, ps, f_c, f_m, f_f};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        circuit_2_sweeper #(.SETTLE_CYCLES(g == 0 ? 2 : 0)) dut (
            .Clock(clk), .Reset(rst[g]), .Start(start[g]), .Abort(abort[g]),
            .Out_1(o1[g]), .Out_2(o2[g]), .Out_3(o3[g]),
            .A(a[g]), .B(b[g]), .C(c[g]), .D(d[g]),
            .Busy(busy[g]), .Done(done[g]), .Aborted(aborted[g]), .Pass(pass[g]),
            .Fail_Count(fc[g]), .Fail_Mask(fm[g]), .First_Fail(ff[g])
        );
        assign vec[g] = {a[g], b[g], c[g], d[g]};
        assign {o1[g], o2[g], o3[g]} = model(vec[g], stuck3, flip_mask);
    end

    task automatic push(input int inst, input int cy, input bit full, input string nm, input logic [32:0] ex);
        snap_t x;
        x = '{inst, cy, full, nm, ex};
        sq.push_back(x);
    endtask

    // stop_k < 0: full sweep; otherwise Abort (or Reset) is sampled on edge e+stop_k.
    // poke1/poke2: extra Start pulses sampled on edge e+poke.
    task automatic sweep(input int inst, input int stop_k, input bit use_reset,
                         input logic [4:0] efc, input logic [15:0] efm, input logic [3:0] eff,
                         input int poke1, input int poke2, input bit abort_with_start);
        int per, e, last, end_c;
        per  = (inst == 0) ? 4 : 2;
        e    = cyc + 1;
        last = (stop_k < 0) ? 16 * per : stop_k;
        for (int k = 0; k < last; k++) begin
            if (stop_k >= 0 && k == stop_k - 1)
                push(inst, e + k, 1'b1, "pre_stop", pack(4'(k / per), 1, 0, 0, 0, efc, efm, eff));
            else
                push(inst, e + k, 1'b0, "vector", pack(4'(k / per), 1, 0, 0, 0, 0, 0, 0));
        end
        if (stop_k < 0) begin
            push(inst, e + 16 * per + 1, 1'b1, "done", pack(4'd15, 0, 1, 0, efc == 0, efc, efm, eff));
            push(inst, e + 16 * per + 2, 1'b1, "after_done", pack(4'd15, 0, 0, 0, efc == 0, efc, efm, eff));
            end_c = e + 16 * per + 3;
        end else begin
            if (use_reset)
                push(inst, e + stop_k, 1'b1, "reset_clear", pack(0, 0, 0, 0, 0, 0, 0, 0));
            else
                push(inst, e + stop_k, 1'b1, "aborted", pack(0, 0, 0, 1, 0, efc, efm, eff));
            end_c = e + stop_k + 2;
        end
        start[inst] = 1'b1;
        abort[inst] = abort_with_start;
        @(negedge clk);
        start[inst] = 1'b0;
        abort[inst] = 1'b0;
        while (cyc < end_c) begin
            if (stop_k >= 0 && cyc == e + stop_k - 1) begin
                if (use_reset) rst[inst] = 1'b1;
                else abort[inst] = 1'b1;
            end
            if ((poke1 >= 0 && cyc == e + poke1 - 1) || (poke2 >= 0 && cyc == e + poke2 - 1))
                start[inst] = 1'b1;
            @(negedge clk);
            rst[inst]   = 1'b0;
            abort[inst] = 1'b0;
            start[inst] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        cov[0] = 1'b0;
        cov[1] = 1'b0;
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            cur = sq.pop_front();
            checks++;
            if (cur.cyc < cyc) begin
                errors++;
                $display("FAIL stale_%s inst%0d: due cycle %0d not checked, now %0d", cur.name, cur.inst, cur.cyc, cyc);
            end else begin
                cov[cur.inst] = 1'b1;
                act = pack(vec[cur.inst], busy[cur.inst], done[cur.inst], aborted[cur.inst],
                           pass[cur.inst], fc[cur.inst], fm[cur.inst], ff[cur.inst]);
                if (cur.full ? (act !== cur.exp) : (act[32:26] !== cur.exp[32:26])) begin
                    errors++;
                    $display("FAIL %s inst%0d cyc%0d: got {vec,busy,done,abrt,pass,cnt,mask,first}=%h expected %h",
                             cur.name, cur.inst, cyc, act, cur.exp);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (!cov[i]) begin
                checks++;
                if (done[i] !== 1'b0 || aborted[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_pulse inst%0d cyc%0d: got done=%b aborted=%b expected 0 0",
                             i, cyc, done[i], aborted[i]);
                end
            end
        end
    end

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        start[0] = 1'b1; start[1] = 1'b0;
        abort[0] = 1'b0; abort[1] = 1'b0;
        push(0, 3, 1'b1, "reset", pack(0, 0, 0, 0, 0, 0, 0, 0));
        push(1, 3, 1'b1, "reset", pack(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0; start[0] = 1'b0;
        @(negedge clk);

        sweep(0, -1, 0, 5'd0, 16'h0000, 4'd0, -1, -1, 1'b1);
        stuck3 = 1'b1;
        sweep(0, -1, 0, 5'd7, 16'hAC8C, 4'd2, -1, -1, 1'b0);
        stuck3 = 1'b0;
        sweep(0, 22, 0, 5'd0, 16'h0000, 4'd0, -1, -1, 1'b0);
        stuck3 = 1'b1;
        sweep(0, 22, 0, 5'd2, 16'h000C, 4'd2, -1, -1, 1'b0);
        sweep(0, 16, 0, 5'd1, 16'h0004, 4'd2, -1, -1, 1'b0);
        stuck3 = 1'b0;
        sweep(0, -1, 0, 5'd0, 16'h0000, 4'd0, -1, -1, 1'b0);
        sweep(0, -1, 0, 5'd0, 16'h0000, 4'd0, 14, 65, 1'b0);
        flip_mask = 16'h0120;
        sweep(0, 38, 1, 5'd2, 16'h0120, 4'd5, -1, -1, 1'b0);
        flip_mask = 16'h0000;
        sweep(0, -1, 0, 5'd0, 16'h0000, 4'd0, -1, -1, 1'b0);
        sweep(1, -1, 0, 5'd0, 16'h0000, 4'd0, -1, -1, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL leftover_snapshots: got %0d pending expected 0", sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/circuit_2_sweeper.md
Name: circuit_2_sweeper

Overview:
Sequencer that drives the 4-input / 3-output Circuit_2 combinational block through all 16 input vectors and checks the outputs against a parameterised expected truth table.
- Sits between the bench or board top and the circuit under test: owns inputs A..D, samples Out_1..Out_3 after a programmable settle time.
- Logs per-vector failures and reports pass/fail.
- Used for on-board self-test and as a reusable stimulus engine for the Circuit_n family.

Parameters:
SETTLE_CYCLES, 2, clock cycles a vector is held before its outputs are sampled (0..255).
EXPECTED, 48'h6B82_6069_02F0, expected {Out_1,Out_2,Out_3} for vector i at bits [3i+2:3i], with Out_1 as the MSB; vector i = {A,B,C,D}, with A as the MSB.

Ports:
Clock  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin sweep; sampled only in IDLE
Abort  in  1  stop sweep at next edge; ignored in IDLE/DONE
Out_1  in  1  DUT output 1
Out_2  in  1  DUT output 2
Out_3  in  1  DUT output 3
A  out  1  DUT input A (vector bit 3)
B  out  1  DUT input B (vector bit 2)
C  out  1  DUT input C (vector bit 1)
D  out  1  DUT input D (vector bit 0)
Busy  out  1  high in SETTLE and SAMPLE
Done  out  1  one-cycle pulse when a full sweep completes
Aborted  out  1  one-cycle pulse when a sweep is abandoned
Pass  out  1  high after a completed sweep with zero mismatches; held until next Start
Fail_Count  out  5  number of mismatching vectors (0..16)
Fail_Mask  out  16  bit i set if vector i mismatched
First_Fail  out  4  index of the lowest mismatching vector; 0 if none

Behaviour:
- Reset, checked before all else: state=IDLE.
- Reset values: A..D=0, Busy=0, Done=0, Aborted=0, Pass=0, Fail_Count=0, Fail_Mask=0, First_Fail=0, internal Index=0, settle counter=0.
- Reset mid-sweep discards all results.
- All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE & Start: Index=0, {A,B,C,D}=0, counter=SETTLE_CYCLES, clear Pass/Fail_Count/Fail_Mask/First_Fail, go to SETTLE.
- IDLE & !Start: hold all outputs, so results stay visible.
- SETTLE: if counter==0 go to SAMPLE; else decrement.
- SAMPLE: compare {Out_1,Out_2,Out_3} against EXPECTED[3*Index+2 -: 3].
  - On mismatch: set Fail_Mask[Index] and increment Fail_Count.
  - If this is the first mismatch (Fail_Count==0 before increment), First_Fail=Index.
  - If Index==15, go to DONE.
  - Else Index+1, drive the new vector on {A,B,C,D} on the same edge, reload counter, go to SETTLE.
- DONE: Done=1 for exactly one cycle; Pass=1 iff Fail_Count==0; go to IDLE.
- Per-vector cost: SETTLE_CYCLES+2 cycles, the vector held stable throughout.
- Done is high in cycle 16*(SETTLE_CYCLES+2)+1 counted from the edge that sampled Start. For SETTLE_CYCLES=2, that is cycle 65.
- Index is 4 bits and never wraps; completion is detected at Index==15, not on overflow.
- Start while Busy or in DONE: ignored.
- Abort in SETTLE/SAMPLE: go to IDLE, Aborted=1 for one cycle, A..D=0, Pass=0.
  - Partial Fail_Count/Fail_Mask/First_Fail are retained for debug.
  - No mismatch is logged on the abort edge.
- Abort and Start in the same IDLE cycle: Start wins, since Abort is ignored in IDLE.
- Reset and Start together: Reset wins.
- Fail_Count saturation is not needed; its maximum is 16, which fits in 5 bits.

Test Plan:
1. Golden DUT, SETTLE_CYCLES=2, pulse Start:
   - A..D step 0000..1111, each held 4 cycles.
   - Done pulse at cycle 65, Pass=1, Fail_Count=0, Fail_Mask=16'h0000, First_Fail=0.
2. DUT with Out_3 stuck at 0 -> Pass=0, Fail_Count=7, Fail_Mask=16'hAC8C, First_Fail=2.
3. Golden DUT, Abort asserted while Index==5 in SETTLE:
   - Next cycle IDLE, Aborted pulse, A..D=0, Busy=0, no Done.
   - A subsequent Start runs a full sweep to Pass=1.
4. Start re-pulsed at Index==3 and again during the DONE cycle -> ignored; sweep ends normally with a single Done pulse.
5. Reset held one cycle at Index==9 with 2 mismatches logged:
   - All outputs return to reset values on the next edge.
   - Start afterwards begins again at vector 0000.
6. SETTLE_CYCLES=0, golden DUT -> each vector held 2 cycles; Done at cycle 33; Pass=1.
